// File: rtl/sram_like_arbiter_pkg.sv
// ============================================================================
// sram_like_arbiter_pkg : shared encodings for the SRAM-like bus arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sram_like_rr_pick.sv
// ============================================================================
// sram_like_rr_pick : combinational 2-way round-robin picker.
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_like_rr_pick
  import sram_like_arbiter_pkg::*;
(
  input  logic req_inst_i,
  input  logic req_data_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic grant_o
);

  // Data wins unless both request and data was served last.
  assign valid_o = req_inst_i | req_data_i;
  assign grant_o = req_data_i & (~req_inst_i | (last_grant_i == GRANT_INST));

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// sram_like_arbiter : two-master / one-slave SRAM-like bus arbiter, one
// transaction (address phase + data phase) outstanding at a time.
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy,
  output logic              grant_data
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;

  logic       pick_valid;
  logic       pick_grant;
  logic       gnt_req;

  sram_like_rr_pick u_pick (
    .req_inst_i   (inst_req),
    .req_data_i   (data_req),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  assign gnt_req = (grant_q == GRANT_DATA) ? data_req : inst_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      grant_q      <= GRANT_INST;
      last_grant_q <= GRANT_INST;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_req        = 1'b0;
    s_wr         = 1'b0;
    s_size       = 2'd0;
    s_addr       = '0;
    s_wdata      = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          state_d = ARB_ADDR;
        end
      end

      ARB_ADDR: begin
        s_req = gnt_req;
        if (grant_q == GRANT_DATA) begin
          s_wr         = data_wr;
          s_size       = data_size;
          s_addr       = data_addr;
          s_wdata      = data_wdata;
          data_addr_ok = s_addr_ok;
        end else begin
          s_wr         = inst_wr;
          s_size       = inst_size;
          s_addr       = inst_addr;
          s_wdata      = inst_wdata;
          inst_addr_ok = s_addr_ok;
        end
        // A dropped request means the slave accepted nothing: abandon it.
        if (!gnt_req) begin
          state_d = ARB_IDLE;
        end else if (s_addr_ok) begin
          state_d      = ARB_DATA;
          last_grant_d = grant_q;
        end
      end

      ARB_DATA: begin
        if (grant_q == GRANT_DATA) begin
          data_data_ok = s_data_ok;
          data_rdata   = s_rdata;
        end else begin
          inst_data_ok = s_data_ok;
          inst_rdata   = s_rdata;
        end
        if (s_data_ok) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != ARB_IDLE);
  assign grant_data = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// tb_sram_like_arbiter : directed bench with a transaction-level model and a
// simple latency-programmable slave.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, s_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok, busy, grant_data;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .busy(busy), .grant_data(grant_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int          addr_lat = 1, data_lat = 2;
  logic [31:0] rdval = 32'h0;
  int          acnt = 0, dcnt = 0;
  bit          acc = 0, pend = 0, wr_l = 0;

  always @(posedge clk) begin
    #1;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = 32'h0;
    if (!resetn) begin
      acnt = 0; dcnt = 0; acc = 0; pend = 0;
    end else begin
      if (acc) begin acc = 0; pend = 1; dcnt = 0; end
      if (pend) begin
        dcnt++;
        if (dcnt >= data_lat) begin
          s_data_ok = 1'b1;
          s_rdata   = wr_l ? 32'h0 : rdval;
          pend      = 0;
        end
      end else if (s_req) begin
        if (acnt >= addr_lat) begin
          s_addr_ok = 1'b1; acc = 1; acnt = 0; wr_l = s_wr;
        end else acnt++;
      end else acnt = 0;
    end
  end

  // ---------------- transaction-level model ----------------
  // phase: 0 nobody owns the slave, 1 owner presenting address, 2 owner awaiting data
  int m_phase = 0;
  bit m_owner_data = 0, m_last_data = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase = 0; m_owner_data = 0; m_last_data = 0;
    end else if (m_phase == 0) begin
      if (inst_req && data_req) begin m_owner_data = !m_last_data; m_phase = 1; end
      else if (inst_req || data_req) begin m_owner_data = data_req; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (!(m_owner_data ? data_req : inst_req)) m_phase = 0;
      else if (s_addr_ok) begin m_phase = 2; m_last_data = m_owner_data; end
    end else if (s_data_ok) m_phase = 0;
  end

  // ---------------- per-cycle compare + event log ----------------
  logic [31:0] addr_log[$];
  bit          gnt_log[$];
  int          n_daok = 0, n_ddok = 0, n_iaok = 0, n_idok = 0;
  logic        cap_wr; logic [1:0] cap_size; logic [31:0] cap_wdata;

  always @(negedge clk) begin
    bit a, d, od;
    #4;
    a = (m_phase == 1); d = (m_phase == 2); od = m_owner_data;
    chk("s_req",   s_req,   a ? (od ? data_req : inst_req) : 1'b0);
    chk("s_wr",    s_wr,    a ? (od ? data_wr : inst_wr) : 1'b0);
    chk("s_size",  s_size,  a ? (od ? data_size : inst_size) : 2'd0);
    chk("s_addr",  s_addr,  a ? (od ? data_addr : inst_addr) : 32'h0);
    chk("s_wdata", s_wdata, a ? (od ? data_wdata : inst_wdata) : 32'h0);
    chk("inst_addr_ok", inst_addr_ok, a && !od && s_addr_ok);
    chk("data_addr_ok", data_addr_ok, a && od && s_addr_ok);
    chk("inst_data_ok", inst_data_ok, d && !od && s_data_ok);
    chk("data_data_ok", data_data_ok, d && od && s_data_ok);
    chk("inst_rdata", inst_rdata, (d && !od) ? s_rdata : 32'h0);
    chk("data_rdata", data_rdata, (d && od) ? s_rdata : 32'h0);
    chk("busy", busy, m_phase != 0);
    chk("grant_data", grant_data, od);
    if (s_req && s_addr_ok) begin addr_log.push_back(s_addr); gnt_log.push_back(grant_data); end
    if (data_addr_ok) begin n_daok++; cap_wr = s_wr; cap_size = s_size; cap_wdata = s_wdata; end
    if (inst_addr_ok) n_iaok++;
    if (data_data_ok) n_ddok++;
    if (inst_data_ok) n_idok++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input bit is_data, input logic [31:0] a, input bit wr,
                        input logic [1:0] sz, input logic [31:0] wd);
    bit ok = 0;
    @(negedge clk);
    if (is_data) begin data_req = 1; data_addr = a; data_wr = wr; data_size = sz; data_wdata = wd; end
    else begin inst_req = 1; inst_addr = a; inst_wr = wr; inst_size = sz; inst_wdata = wd; end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (is_data ? data_addr_ok : inst_addr_ok) begin ok = 1; break; end
    end
    if (!ok) begin tests++; fails++; $display("FAIL addr_ok_timeout: got 0 expected 1"); end
    @(negedge clk);
    if (is_data) data_req = 0; else inst_req = 0;
  endtask

  task automatic wait_done(input bit is_data, output logic [31:0] rd);
    bit ok = 0;
    rd = 32'h0;
    for (int i = 0; i < 60; i++) begin
      if (is_data ? data_data_ok : inst_data_ok) begin
        ok = 1; rd = is_data ? data_rdata : inst_rdata; break;
      end
      @(negedge clk);
    end
    if (!ok) begin tests++; fails++; $display("FAIL data_ok_timeout: got 0 expected 1"); end
  endtask

  task automatic clear_logs();
    addr_log.delete(); gnt_log.delete();
    n_daok = 0; n_ddok = 0; n_iaok = 0; n_idok = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;
    resetn = 0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    #3;
    chk("rst_busy", busy, 0); chk("rst_s_req", s_req, 0); chk("rst_grant", grant_data, 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);

    // contention from reset: data first, then inst
    rdval = 32'h1111_0000;
    fork
      do_req(1, 32'h1FC0_0020, 0, 2'd2, 0);
      do_req(0, 32'hBFC0_0000, 0, 2'd2, 0);
    join
    wait_done(0, rd);
    repeat (2) @(negedge clk);
    chk("cont_n", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("cont_addr0", addr_log[0], 32'h1FC0_0020);
      chk("cont_addr1", addr_log[1], 32'hBFC0_0000);
      chk("cont_gnt0", gnt_log[0], 1);
      chk("cont_gnt1", gnt_log[1], 0);
    end
    clear_logs();

    // fairness: both held for four transactions
    @(negedge clk);
    data_req = 1; data_addr = 32'h1FC0_0030; data_wr = 0; data_size = 2'd2;
    inst_req = 1; inst_addr = 32'hBFC0_0004; inst_wr = 0; inst_size = 2'd2;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (data_data_ok || inst_data_ok) n++;
    end
    data_req = 0; inst_req = 0;
    repeat (3) @(negedge clk);
    chk("rr_done", n_ddok + n_idok, 4);
    chk("rr_n", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      chk("rr_g0", gnt_log[0], 1); chk("rr_g1", gnt_log[1], 0);
      chk("rr_g2", gnt_log[2], 1); chk("rr_g3", gnt_log[3], 0);
      chk("rr_a1", addr_log[1], 32'hBFC0_0004);
    end
    clear_logs();

    // single data read
    rdval = 32'hDEAD_BEEF;
    do_req(1, 32'h1FC0_0010, 0, 2'd2, 0);
    wait_done(1, rd);
    chk("rd_rdata", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_busy_after", busy, 0);
    @(negedge clk);
    chk("rd_daok_n", n_daok, 1); chk("rd_iaok_n", n_iaok, 0); chk("rd_idok_n", n_idok, 0);
    if (addr_log.size() > 0) chk("rd_addr", addr_log[0], 32'h1FC0_0010);
    else chk("rd_addr_n", addr_log.size(), 1);
    clear_logs();

    // byte write
    rdval = 32'h1234_5678;
    do_req(1, 32'h8000_0003, 1, 2'd0, 32'h0000_00AA);
    wait_done(1, rd);
    chk("wr_rdata", rd, 32'h0);
    @(negedge clk);
    chk("wr_s_wr", cap_wr, 1); chk("wr_s_size", cap_size, 0); chk("wr_s_wdata", cap_wdata, 32'hAA);
    chk("wr_ddok_n", n_ddok, 1);
    data_wr = 0;
    clear_logs();

    // cancel: inst drops request before addr_ok
    addr_lat = 10;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0008;
    #4 chk("cx_bubble", s_req, 0);
    repeat (3) @(negedge clk);
    chk("cx_busy", busy, 1); chk("cx_gnt", grant_data, 0);
    inst_req = 0;
    #1 chk("cx_sreq_drop", s_req, 0);
    @(negedge clk);
    chk("cx_idle", busy, 0);
    chk("cx_iaok_n", n_iaok, 0);
    addr_lat = 1;
    clear_logs();

    // asynchronous reset in the data phase
    data_lat = 6;
    do_req(1, 32'h1FC0_0040, 0, 2'd2, 0);
    #1 chk("rs_busy_pre", busy, 1); chk("rs_gnt_pre", grant_data, 1);
    #2 resetn = 0;
    #1;
    chk("rs_busy", busy, 0); chk("rs_gnt", grant_data, 0); chk("rs_s_req", s_req, 0);
    chk("rs_s_addr", s_addr, 0); chk("rs_ddok", data_data_ok, 0); chk("rs_drdata", data_rdata, 0);
    @(negedge clk);
    resetn = 1;
    data_lat = 2;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    #4 chk("rs2_bubble", s_req, 0);
    @(negedge clk);
    #4 chk("rs2_sreq", s_req, 1); chk("rs2_addr", s_addr, 32'hBFC0_0000);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_addr_ok) begin n = 1; break; end
    end
    chk("rs2_aok", n, 1);
    @(negedge clk);
    inst_req = 0;
    wait_done(0, rd);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
